flash_stream_reader: RTL and testbench
======================================

Name: flash_stream_reader

Overview:
Bus master that sits directly upstream of the SPI flash controller. On a start command it issues sequential 32-bit read requests over the flash controller's stb/ack/rty bus, retries on rty with a programmable back-off, and buffers returned words in a small FIFO. A downstream consumer (patch/sample loader) pops words through a valid/ready interface.

Parameters:
FIFO_DEPTH, 4, word FIFO depth; power of 2, >=2
RETRY_GAP, 16, clk_i cycles with stb low between an rty and the reissue of the same request
MAX_RETRY, 255, consecutive rty count on one address before error; 8-bit counter
ADR_STEP, 4, byte increment of the address per word

Ports:
clk_i  in  1  system clock, 100 MHz
rst_i  in  1  synchronous, active-high reset
start_i  in  1  one-cycle start pulse; ignored while busy_o=1
base_adr_i  in  24  first byte address; sampled on accepted start
word_cnt_i  in  16  number of words to read; sampled on accepted start
abort_i  in  1  cancel current transfer
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse: all words popped by consumer
err_o  out  1  sticky retry-limit error; cleared by next accepted start
m_adr_o  out  24  request address to flash controller
m_dat_o  out  32  write data; constant 0
m_we_o  out  1  constant 0 (read only)
m_stb_o  out  1  request strobe
m_dat_i  in  32  read data from flash controller
m_ack_i  in  1  request completed, data valid
m_rty_i  in  1  controller busy, retry
word_o  out  32  FIFO head word
word_valid_o  out  1  FIFO not empty
word_ready_i  in  1  consumer pop
fifo_level_o  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: busy_o=0, done_o=0, err_o=0, m_stb_o=0, m_adr_o=0, word_valid_o=0, fifo_level_o=0, state=IDLE, FIFO flushed, counters zero.
- States: IDLE, REQ, GAP, BACKOFF, DRAIN.
- IDLE: start_i=1 -> latch base_adr_i into m_adr_o, word_cnt_i into remaining count, retry count=0, clear err_o, busy_o=1; go REQ next cycle. If word_cnt_i=0 -> go DRAIN directly (done_o pulses one cycle after the start cycle).
- REQ: m_stb_o=1 only when fifo_level_o < FIFO_DEPTH; otherwise stb stays low, still in REQ. Once asserted, stb is held with constant address until m_ack_i or m_rty_i; it is never withdrawn early except on abort/reset.
- m_ack_i=1 while stb high: push m_dat_i into FIFO same edge, m_stb_o=0 next cycle, m_adr_o += ADR_STEP (24-bit wrap: 0xFFFFFC -> 0x000000), remaining -= 1, retry count=0; go GAP.
- m_rty_i=1 while stb high: m_stb_o=0, retry count += 1; if new count > MAX_RETRY -> err_o=1, go DRAIN (no more requests); else go BACKOFF.
- ack and rty in the same cycle: ack wins. ack/rty while stb low: ignored.
- GAP: exactly one cycle stb low (lets the controller return to idle and deselect CS); then REQ if remaining != 0, else DRAIN.
- BACKOFF: stb low for RETRY_GAP cycles, then REQ with the unchanged address.
- DRAIN: wait for FIFO empty; then done_o=1 for one cycle (only if err_o=0), busy_o=0, go IDLE. With err_o=1: return to IDLE on FIFO empty with no done_o.
- FIFO: push on ack, pop on word_valid_o & word_ready_i; simultaneous push and pop leaves the level unchanged. word_o is valid whenever word_valid_o=1 and is stable until popped. The push never overflows because REQ gates stb on level < FIFO_DEPTH, with at most 1 request outstanding.
- abort_i (any state except IDLE): m_stb_o=0 next cycle, FIFO flushed, busy_o=0, state IDLE, no done_o, err_o unchanged. abort_i in IDLE has no effect. rst_i overrides all.
- start_i while busy_o=1: ignored.

Test Plan:
- base=0x000100, cnt=3, slave acks each request 4 cycles after stb, consumer always ready -> addresses 0x100, 0x104, 0x108 each issued once, stb low >=1 cycle between requests, 3 words out in order, done_o one pulse, busy_o falls.
- cnt=6, consumer ready=0 -> exactly 4 acks, then stb held low with fifo_level_o=4; raise ready -> remaining 2 words fetched, done_o after 6 pops.
- Slave answers rty twice then ack at 0x000200, RETRY_GAP=16 -> stb low >=16 cycles after each rty, same address reissued 3 times, one word pushed, err_o=0.
- MAX_RETRY=3, slave always rty -> 4 strobes total, err_o=1, no done_o, busy_o=0 once FIFO empty; next start clears err_o.
- base=0xFFFFFC, cnt=2 -> second request at 0x000000.
- Abort mid-stb after 1 word buffered -> stb low next cycle, fifo_level_o=0, busy_o=0, no done_o; cnt=0 start -> done_o pulse with no bus activity.

Source files
------------

// File: rtl/flash_stream_reader.sv
// Sequential read master for the SPI flash controller bus: issues one request
// at a time, backs off on rty, and buffers returned words for a valid/ready consumer.
module flash_stream_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int RETRY_GAP  = 16,
  parameter int MAX_RETRY  = 255,
  parameter int ADR_STEP   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [23:0]                  base_adr_i,
  input  logic [15:0]                  word_cnt_i,
  input  logic                         abort_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [23:0]                  m_adr_o,
  output logic [31:0]                  m_dat_o,
  output logic                         m_we_o,
  output logic                         m_stb_o,
  input  logic [31:0]                  m_dat_i,
  input  logic                         m_ack_i,
  input  logic                         m_rty_i,
  output logic [31:0]                  word_o,
  output logic                         word_valid_o,
  input  logic                         word_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_BACKOFF,
    ST_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [23:0]   r_adr;
  logic [15:0]   r_remain;
  logic [7:0]    r_retry;
  logic          r_err;
  logic [GW-1:0] r_gapCnt;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [PW:0]   r_level;

  logic          w_stb;
  logic          w_start;
  logic          w_abort;
  logic          w_ack;
  logic          w_rty;
  logic          w_push;
  logic          w_pop;
  logic [8:0]    w_retryNext;
  logic          w_retryOver;
  logic          w_gapDone;

  // The strobe is a pure function of registered state, so it cannot drop mid-request:
  // the level can only fall while REQ waits, never rise without an ack.
  assign w_stb       = (r_state == ST_REQ) && (r_level < (PW+1)'(FIFO_DEPTH));
  assign w_start     = (r_state == ST_IDLE) && start_i;
  assign w_abort     = (r_state != ST_IDLE) && abort_i;
  assign w_ack       = w_stb && m_ack_i;
  assign w_rty       = w_stb && m_rty_i && !m_ack_i;
  assign w_push      = w_ack;
  assign w_pop       = (r_level != '0) && word_ready_i;
  assign w_retryNext = {1'b0, r_retry} + 9'd1;
  assign w_retryOver = w_retryNext > 9'(MAX_RETRY);
  assign w_gapDone   = r_gapCnt == GW'(RETRY_GAP - 1);

  assign busy_o       = r_state != ST_IDLE;
  assign done_o       = (r_state == ST_DRAIN) && (r_level == '0) && !r_err && !abort_i && !rst_i;
  assign err_o        = r_err;
  assign m_adr_o      = r_adr;
  assign m_dat_o      = '0;
  assign m_we_o       = 1'b0;
  assign m_stb_o      = w_stb;
  assign word_o       = r_mem[r_rdPtr];
  assign word_valid_o = r_level != '0;
  assign fifo_level_o = r_level;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) w_next = (word_cnt_i == '0) ? ST_DRAIN : ST_REQ;
      end
      ST_REQ: begin
        if (w_ack)      w_next = ST_GAP;
        else if (w_rty) w_next = w_retryOver ? ST_DRAIN : ST_BACKOFF;
      end
      ST_GAP:     w_next = (r_remain != '0) ? ST_REQ : ST_DRAIN;
      ST_BACKOFF: if (w_gapDone) w_next = ST_REQ;
      ST_DRAIN:   if (r_level == '0) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_adr    <= '0;
      r_remain <= '0;
      r_retry  <= '0;
      r_err    <= 1'b0;
      r_gapCnt <= '0;
    end else if (w_start) begin
      r_adr    <= base_adr_i;
      r_remain <= word_cnt_i;
      r_retry  <= '0;
      r_err    <= 1'b0;
    end else if (!w_abort) begin
      if (w_ack) begin
        r_adr    <= r_adr + 24'(ADR_STEP);
        r_remain <= r_remain - 16'd1;
        r_retry  <= '0;
      end else if (w_rty) begin
        r_retry  <= w_retryNext[7:0];
        r_gapCnt <= '0;
        if (w_retryOver) r_err <= 1'b1;
      end
      if (r_state == ST_BACKOFF) r_gapCnt <= r_gapCnt + GW'(1);
    end
  end

  // Abort flushes by rewinding the pointers; a word acked in the abort cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_abort) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (PW+1)'(1);
        2'b01:   r_level <= r_level - (PW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr] <= m_dat_i;
  end

endmodule

// File: tb/tb_flash_stream_reader.sv
// Randomized bench for flash_stream_reader: a bus slave and consumer drive the DUT,
// and a transaction-level model predicts every output on every cycle.
module tb_flash_stream_reader;

  localparam int FIFO_DEPTH = 4;
  localparam int RETRY_GAP  = 16;
  localparam int MAX_RETRY  = 3;
  localparam int ADR_STEP   = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [23:0] base_adr_i = '0;
  logic [15:0] word_cnt_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, err_o, m_we_o, m_stb_o;
  logic [23:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;
  logic        m_rty_i = 1'b0;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_o;

  always #5 clk_i = ~clk_i;

  flash_stream_reader #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .RETRY_GAP (RETRY_GAP),
    .MAX_RETRY (MAX_RETRY),
    .ADR_STEP  (ADR_STEP)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_adr_i  (base_adr_i),
    .word_cnt_i  (word_cnt_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .m_adr_o     (m_adr_o),
    .m_dat_o     (m_dat_o),
    .m_we_o      (m_we_o),
    .m_stb_o     (m_stb_o),
    .m_dat_i     (m_dat_i),
    .m_ack_i     (m_ack_i),
    .m_rty_i     (m_rty_i),
    .word_o      (word_o),
    .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i),
    .fifo_level_o(fifo_level_o)
  );

  int checks = 0;
  int errors = 0;

  // slave and consumer knobs
  int slvLat = 4, slvWait = 0, slvRtyBefore = 0, slvRtyDone = 0, slvRtyPct = 0;
  bit slvAlwaysRty = 0, slvRand = 0;
  int readyPct = 100;

  // transfer model
  bit          mBusy = 0, mErr = 0;
  logic [23:0] mBase = '0;
  int          mCnt = 0, mAcks = 0, mPops = 0, mLevel = 0;
  int          mRtyRun = 0, mLowCnt = 0, mReqGap = 1;

  // per-test statistics for the literal expectations
  int          strobes = 0, ackCount = 0, popCount = 0, doneCount = 0;
  int          minGap = 1000, lowRun = 0;
  bit          prevStb = 0;
  logic [23:0] adrLog[$];

  function automatic logic [31:0] dataOf(input logic [23:0] a);
    return {a[7:0] ^ 8'h5A, a} ^ 32'h0F0F_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave and consumer respond, then outputs are compared with the model one step later.
  always @(negedge clk_i) begin
    logic        expStb, expDone, ackEv, rtyEv, popEv, ended;
    logic [23:0] expAdr;
    m_ack_i = 1'b0;
    m_rty_i = 1'b0;
    m_dat_i = $urandom;
    word_ready_i = ($urandom_range(0, 99) < readyPct);
    if (m_stb_o) begin
      if (slvWait >= slvLat) begin
        slvWait = 0;
        if (slvRand) slvLat = $urandom_range(0, 3);
        if (slvAlwaysRty || slvRtyDone < slvRtyBefore ||
            (slvRand && $urandom_range(0, 99) < slvRtyPct)) begin
          m_rty_i = 1'b1;
          slvRtyDone++;
        end else begin
          m_ack_i = 1'b1;
          m_dat_i = dataOf(m_adr_o);
          slvRtyDone = 0;
          if (slvRand && $urandom_range(0, 9) == 0) m_rty_i = 1'b1;
        end
      end else slvWait++;
    end else begin
      slvWait = 0;
      if (slvRand && $urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 1) m_ack_i = 1'b1;
        else m_rty_i = 1'b1;
      end
    end
    #1;
    expStb  = mBusy && !mErr && (mAcks < mCnt) && (mLevel < FIFO_DEPTH) && (mLowCnt >= mReqGap);
    expDone = mBusy && !mErr && (mAcks == mCnt) && (mLevel == 0) && !abort_i && !rst_i;
    expAdr  = mBase + 24'(ADR_STEP * mAcks);
    if (rst_i) begin
      mBusy = 0; mErr = 0; mLevel = 0; mAcks = 0; mPops = 0; mCnt = 0;
    end else begin
      checkOutput("busy", busy_o, mBusy);
      checkOutput("err", err_o, mErr);
      checkOutput("level", fifo_level_o, mLevel);
      checkOutput("valid", word_valid_o, mLevel != 0);
      if (mLevel != 0) checkOutput("word", word_o, dataOf(mBase + 24'(ADR_STEP * mPops)));
      checkOutput("stb", m_stb_o, expStb);
      if (expStb) checkOutput("adr", m_adr_o, expAdr);
      checkOutput("done", done_o, expDone);
      checkOutput("we", m_we_o, 1'b0);
      checkOutput("wdat", m_dat_o, 32'h0);
      if (m_stb_o && !prevStb) begin
        if (strobes > 0 && lowRun < minGap) minGap = lowRun;
        strobes++;
        adrLog.push_back(m_adr_o);
        lowRun = 0;
      end else if (!m_stb_o) lowRun++;
      prevStb = m_stb_o;
      ackEv = m_stb_o && m_ack_i;
      rtyEv = m_stb_o && m_rty_i && !m_ack_i;
      popEv = word_valid_o && word_ready_i;
      if (ackEv) ackCount++;
      if (popEv) popCount++;
      if (done_o) doneCount++;
      if (!mBusy) begin
        if (start_i) begin
          mBusy = 1; mErr = 0; mBase = base_adr_i; mCnt = int'(word_cnt_i);
          mAcks = 0; mPops = 0; mLevel = 0; mRtyRun = 0;
          mLowCnt = RETRY_GAP; mReqGap = 1;
        end
      end else if (abort_i) begin
        mBusy = 0;
        mLevel = 0;
      end else begin
        ended = (mLevel == 0) && (mErr || mAcks == mCnt);
        if (ended) mBusy = 0;
        else begin
          if (ackEv) begin
            mAcks++; mLevel++; mRtyRun = 0; mLowCnt = 0; mReqGap = 1;
          end else if (rtyEv) begin
            mRtyRun++;
            if (mRtyRun > MAX_RETRY) mErr = 1;
            mLowCnt = 0; mReqGap = RETRY_GAP;
          end else if (!m_stb_o && mLowCnt < 1000) mLowCnt++;
          if (popEv) begin
            mPops++; mLevel--;
          end
        end
      end
    end
  end

  task automatic clearStats();
    strobes = 0; ackCount = 0; popCount = 0; doneCount = 0;
    minGap = 1000; lowRun = 0;
    adrLog.delete();
  endtask

  task automatic applyStimulus(input logic [23:0] base, input logic [15:0] cnt);
    @(negedge clk_i);
    base_adr_i = base;
    word_cnt_i = cnt;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    base_adr_i = $urandom;
    word_cnt_i = $urandom;
  endtask

  task automatic pulseAbort();
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk_i);
    while ((busy_o || mBusy) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput(name, n < budget, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [23:0] e1 [3];
    int n;
    e1[0] = 24'h000100; e1[1] = 24'h000104; e1[2] = 24'h000108;

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_done", done_o, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_stb", m_stb_o, 1'b0);
    checkOutput("rst_adr", m_adr_o, 24'h0);
    checkOutput("rst_valid", word_valid_o, 1'b0);
    checkOutput("rst_level", fifo_level_o, 3'd0);

    $display("[TB] three words, slave latency 4, consumer always ready");
    clearStats();
    slvLat = 4; readyPct = 100;
    applyStimulus(24'h000100, 16'd3);
    waitIdle(200, "t1_timeout");
    checkOutput("t1_strobes", strobes, 3);
    for (int i = 0; i < 3; i++)
      if (adrLog.size() > i) checkOutput("t1_adr", adrLog[i], e1[i]);
    checkOutput("t1_mingap", minGap, 1);
    checkOutput("t1_pops", popCount, 3);
    checkOutput("t1_done", doneCount, 1);

    $display("[TB] six words with a stalled consumer");
    clearStats();
    slvLat = 1; readyPct = 0;
    applyStimulus(24'h001000, 16'd6);
    repeat (40) @(negedge clk_i);
    checkOutput("t2_acks", ackCount, 4);
    checkOutput("t2_level", fifo_level_o, 3'd4);
    checkOutput("t2_stb", m_stb_o, 1'b0);
    checkOutput("t2_busy", busy_o, 1'b1);
    readyPct = 100;
    waitIdle(200, "t2_timeout");
    checkOutput("t2_acks_all", ackCount, 6);
    checkOutput("t2_pops", popCount, 6);
    checkOutput("t2_done", doneCount, 1);

    $display("[TB] two retries then ack");
    clearStats();
    slvLat = 2; slvRtyDone = 0; slvRtyBefore = 2;
    applyStimulus(24'h000200, 16'd1);
    waitIdle(300, "t3_timeout");
    checkOutput("t3_strobes", strobes, 3);
    for (int i = 0; i < 3; i++)
      if (adrLog.size() > i) checkOutput("t3_adr", adrLog[i], 24'h000200);
    checkOutput("t3_mingap", minGap, RETRY_GAP);
    checkOutput("t3_acks", ackCount, 1);
    checkOutput("t3_err", err_o, 1'b0);
    checkOutput("t3_done", doneCount, 1);
    slvRtyBefore = 0;

    $display("[TB] slave always retries");
    clearStats();
    slvAlwaysRty = 1;
    applyStimulus(24'h000300, 16'd5);
    waitIdle(300, "t4_timeout");
    checkOutput("t4_strobes", strobes, MAX_RETRY + 1);
    checkOutput("t4_err", err_o, 1'b1);
    checkOutput("t4_done", doneCount, 0);
    checkOutput("t4_busy", busy_o, 1'b0);
    slvAlwaysRty = 0;
    slvRtyDone = 0;
    applyStimulus(24'h000400, 16'd1);
    checkOutput("t4_errclr", err_o, 1'b0);
    waitIdle(200, "t4b_timeout");

    $display("[TB] address wrap");
    clearStats();
    applyStimulus(24'hFFFFFC, 16'd2);
    waitIdle(200, "t5_timeout");
    checkOutput("t5_strobes", strobes, 2);
    if (adrLog.size() > 1) checkOutput("t5_wrap", adrLog[1], 24'h000000);

    $display("[TB] abort with one word buffered, then empty transfer");
    clearStats();
    slvLat = 1; readyPct = 0;
    applyStimulus(24'h000500, 16'd5);
    n = 0;
    while (!(ackCount >= 1 && m_stb_o) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("t6_reach", n < 50, 1'b1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #2;
    checkOutput("t6_stb", m_stb_o, 1'b0);
    checkOutput("t6_level", fifo_level_o, 3'd0);
    checkOutput("t6_busy", busy_o, 1'b0);
    checkOutput("t6_done", doneCount, 0);
    readyPct = 100;
    clearStats();
    applyStimulus(24'h000600, 16'd0);
    #2;
    checkOutput("t6_cnt0_done", done_o, 1'b1);
    waitIdle(50, "t6_timeout");
    checkOutput("t6_cnt0_pulses", doneCount, 1);
    checkOutput("t6_cnt0_strobes", strobes, 0);

    $display("[TB] randomized transfers");
    slvRand = 1;
    for (int t = 0; t < 40; t++) begin
      slvRtyPct = $urandom_range(0, 30);
      readyPct = $urandom_range(20, 100);
      applyStimulus(24'($urandom), 16'($urandom_range(0, 8)));
      repeat ($urandom_range(0, 20)) @(negedge clk_i);
      case ($urandom_range(0, 3))
        0: pulseAbort();
        1: applyStimulus(24'($urandom), 16'($urandom_range(0, 8)));
        default: ;
      endcase
      waitIdle(3000, "rand_timeout");
    end
    slvRand = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
